data_sram_axi_bridge: RTL and testbench

Responder for the data-memory request interface driven by the execute stage (`data_sram_en/we/addr/wdata`). It accepts one request at a time, converts it into a single-beat AXI4 read or write transaction, and returns read data with a one-cycle `data_ok` pulse. It sits between the execute/memory stages and the top-level AXI interconnect. It replaces the zero-latency SRAM model with a stallable, variable-latency path.

---
 rtl/data_sram_axi_bridge_pkg.sv | 18 +
 rtl/data_sram_axi_bridge.sv | 156 +++++++++++++++
 tb/tb_data_sram_axi_bridge.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_sram_axi_bridge_pkg.sv
// Shared encodings for the data-side SRAM-to-AXI bridge: FSM states and the
// fixed AXI transfer attributes used for single-beat word accesses.
package data_sram_axi_bridge_pkg;

  typedef enum logic [2:0] {
    BR_IDLE,
    BR_AR,
    BR_R,
    BR_AWW,
    BR_B,
    BR_RESP
  } br_state_e;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/data_sram_axi_bridge.sv
// Data-memory request responder: one outstanding request, turned into a
// single-beat AXI4 read or write, answered with a one-cycle data_ok pulse.
module data_sram_axi_bridge
  import data_sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  input  logic        cancel,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        bus_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  br_state_e state;
  logic      cancelled;
  logic      aw_done, w_done;
  logic      aw_hs, w_hs, kill;
  logic      unused_ok;

  assign arid    = AXI_ID;
  assign awid    = AXI_ID;
  assign arlen   = 8'd0;
  assign awlen   = 8'd0;
  assign arsize  = AXI_SIZE_4B;
  assign awsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;
  assign awburst = AXI_BURST_INCR;
  assign wlast   = 1'b1;

  // Single-beat reads: the last flag carries no extra information.
  assign unused_ok = rlast;

  assign data_sram_addr_ok = (state == BR_IDLE);
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  // A flush seen on the completing beat must also suppress the response.
  assign kill  = cancelled || cancel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= BR_IDLE;
      cancelled         <= 1'b0;
      aw_done           <= 1'b0;
      w_done            <= 1'b0;
      arvalid           <= 1'b0;
      rready            <= 1'b0;
      awvalid           <= 1'b0;
      wvalid            <= 1'b0;
      bready            <= 1'b0;
      araddr            <= '0;
      awaddr            <= '0;
      wdata             <= '0;
      wstrb             <= '0;
      data_sram_rdata   <= '0;
      data_sram_data_ok <= 1'b0;
      bus_err           <= 1'b0;
    end else begin
      data_sram_data_ok <= 1'b0;
      bus_err           <= 1'b0;
      if (state != BR_IDLE && cancel) cancelled <= 1'b1;

      case (state)
        BR_IDLE: if (data_sram_en) begin
          cancelled <= 1'b0;
          wdata     <= data_sram_wdata;
          wstrb     <= data_sram_we;
          if (data_sram_we == 4'b0) begin
            araddr  <= {data_sram_addr[31:2], 2'b00};
            arvalid <= 1'b1;
            state   <= BR_AR;
          end else begin
            awaddr  <= data_sram_addr;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= BR_AWW;
          end
        end
        BR_AR: if (arready) begin
          arvalid <= 1'b0;
          rready  <= 1'b1;
          state   <= BR_R;
        end
        BR_R: if (rvalid) begin
          rready <= 1'b0;
          if (!kill) begin
            data_sram_rdata   <= rdata;
            data_sram_data_ok <= 1'b1;
            bus_err           <= (rresp != AXI_RESP_OKAY);
          end
          state <= BR_RESP;
        end
        BR_AWW: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            bready <= 1'b1;
            state  <= BR_B;
          end
        end
        BR_B: if (bvalid) begin
          bready <= 1'b0;
          if (!kill) begin
            data_sram_data_ok <= 1'b1;
            bus_err           <= (bresp != AXI_RESP_OKAY);
          end
          state <= BR_RESP;
        end
        BR_RESP: state <= BR_IDLE;
        default: state <= BR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Directed bench for data_sram_axi_bridge: the testbench plays the AXI slave
// cycle by cycle and checks every output against hand-computed values.
module tb_data_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        cancel;
  logic        data_sram_addr_ok, data_sram_data_ok, bus_err;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, awid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int n_chk = 0;
  int n_fail = 0;
  int ok_cnt = 0;
  int ok_base;

  data_sram_axi_bridge #(.AXI_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .cancel(cancel),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .bus_err(bus_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (data_sram_data_ok) ok_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    data_sram_en = 0; data_sram_we = 0; data_sram_addr = 0; data_sram_wdata = 0;
    cancel = 0;
    arready = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0;

    // reset state and constant fields
    @(negedge clk); @(negedge clk);
    chk("rst_arvalid", {31'b0, arvalid}, 32'd0);
    chk("rst_awvalid", {31'b0, awvalid}, 32'd0);
    chk("rst_wvalid", {31'b0, wvalid}, 32'd0);
    chk("rst_rready", {31'b0, rready}, 32'd0);
    chk("rst_bready", {31'b0, bready}, 32'd0);
    chk("rst_data_ok", {31'b0, data_sram_data_ok}, 32'd0);
    chk("rst_rdata", data_sram_rdata, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_wstrb", {28'b0, wstrb}, 32'd0);
    chk("const_arlen", {24'b0, arlen}, 32'd0);
    chk("const_awburst", {30'b0, awburst}, 32'd1);
    chk("const_awsize", {29'b0, awsize}, 32'd2);
    chk("const_arid", {28'b0, arid}, 32'd1);
    chk("const_awid", {28'b0, awid}, 32'd1);
    rst = 1'b0;
    step();
    chk("idle_addr_ok", {31'b0, data_sram_addr_ok}, 32'd1);

    // read 0x1C00_0004, rvalid two cycles after the AR handshake
    ok_base = ok_cnt;
    data_sram_en = 1; data_sram_we = 0; data_sram_addr = 32'h1C00_0004;
    step();
    data_sram_en = 0;
    chk("rd_arvalid", {31'b0, arvalid}, 32'd1);
    chk("rd_araddr", araddr, 32'h1C00_0004);
    chk("rd_arsize", {29'b0, arsize}, 32'd2);
    chk("rd_busy_addr_ok", {31'b0, data_sram_addr_ok}, 32'd0);
    arready = 1;
    step();
    arready = 0;
    chk("rd_arvalid_drop", {31'b0, arvalid}, 32'd0);
    chk("rd_rready", {31'b0, rready}, 32'd1);
    step();
    chk("rd_wait_ok", {31'b0, data_sram_data_ok}, 32'd0);
    rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
    step();
    rvalid = 0;
    chk("rd_data_ok", {31'b0, data_sram_data_ok}, 32'd1);
    chk("rd_rdata", data_sram_rdata, 32'hDEAD_BEEF);
    chk("rd_bus_err", {31'b0, bus_err}, 32'd0);
    step();
    chk("rd_ok_count", ok_cnt - ok_base, 32'd1);
    chk("rd_back_idle", {31'b0, data_sram_addr_ok}, 32'd1);

    // byte write; cancel in the accept cycle must be ignored
    ok_base = ok_cnt;
    data_sram_en = 1; data_sram_we = 4'b0100; data_sram_addr = 32'h0000_0102;
    data_sram_wdata = 32'h5A5A_5A5A; cancel = 1;
    step();
    data_sram_en = 0; cancel = 0;
    chk("wr_awvalid", {31'b0, awvalid}, 32'd1);
    chk("wr_wvalid", {31'b0, wvalid}, 32'd1);
    chk("wr_awaddr", awaddr, 32'h0000_0102);
    chk("wr_wstrb", {28'b0, wstrb}, 32'h4);
    chk("wr_wdata", wdata, 32'h5A5A_5A5A);
    chk("wr_wlast", {31'b0, wlast}, 32'd1);
    awready = 1; wready = 1;
    step();
    awready = 0; wready = 0;
    chk("wr_aw_drop", {31'b0, awvalid}, 32'd0);
    chk("wr_bready", {31'b0, bready}, 32'd1);
    bvalid = 1; bresp = 2'b00;
    step();
    bvalid = 0;
    chk("wr_data_ok", {31'b0, data_sram_data_ok}, 32'd1);
    chk("wr_bus_err", {31'b0, bus_err}, 32'd0);
    step();
    chk("wr_ok_count", ok_cnt - ok_base, 32'd1);

    // staggered write: W handshakes three cycles before AW
    data_sram_en = 1; data_sram_we = 4'hF; data_sram_addr = 32'h0000_0200;
    data_sram_wdata = 32'h1122_3344;
    step();
    data_sram_en = 0;
    wready = 1;
    step();
    wready = 0;
    chk("stg_w_drop", {31'b0, wvalid}, 32'd0);
    chk("stg_aw_held1", {31'b0, awvalid}, 32'd1);
    chk("stg_no_b1", {31'b0, bready}, 32'd0);
    step();
    chk("stg_aw_held2", {31'b0, awvalid}, 32'd1);
    step();
    chk("stg_aw_held3", {31'b0, awvalid}, 32'd1);
    chk("stg_no_b3", {31'b0, bready}, 32'd0);
    chk("stg_awaddr", awaddr, 32'h0000_0200);
    awready = 1;
    step();
    awready = 0;
    chk("stg_aw_drop", {31'b0, awvalid}, 32'd0);
    chk("stg_bready", {31'b0, bready}, 32'd1);
    bvalid = 1;
    step();
    bvalid = 0;
    chk("stg_data_ok", {31'b0, data_sram_data_ok}, 32'd1);
    step();

    // read cancelled in R: transaction completes silently
    ok_base = ok_cnt;
    data_sram_en = 1; data_sram_we = 0; data_sram_addr = 32'h0000_0300;
    step();
    data_sram_en = 0; arready = 1;
    step();
    arready = 0;
    cancel = 1; rvalid = 1; rdata = 32'h1234_5678;
    step();
    cancel = 0; rvalid = 0;
    chk("cxl_rready_drop", {31'b0, rready}, 32'd0);
    chk("cxl_no_data_ok", {31'b0, data_sram_data_ok}, 32'd0);
    chk("cxl_rdata_kept", data_sram_rdata, 32'hDEAD_BEEF);
    step();
    chk("cxl_addr_ok", {31'b0, data_sram_addr_ok}, 32'd1);
    chk("cxl_ok_count", ok_cnt - ok_base, 32'd0);

    // read with SLVERR
    data_sram_en = 1; data_sram_we = 0; data_sram_addr = 32'h0000_0403;
    step();
    data_sram_en = 0;
    chk("err_araddr_align", araddr, 32'h0000_0400);
    arready = 1;
    step();
    arready = 0;
    rvalid = 1; rdata = 32'hCAFE_F00D; rresp = 2'b10;
    step();
    rvalid = 0; rresp = 2'b00;
    chk("err_data_ok", {31'b0, data_sram_data_ok}, 32'd1);
    chk("err_bus_err", {31'b0, bus_err}, 32'd1);
    chk("err_rdata", data_sram_rdata, 32'hCAFE_F00D);
    step();
    chk("err_bus_err_pulse", {31'b0, bus_err}, 32'd0);

    // asynchronous reset while arvalid is high
    data_sram_en = 1; data_sram_we = 0; data_sram_addr = 32'h0000_0500;
    step();
    data_sram_en = 0;
    chk("ar_before_rst", {31'b0, arvalid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_arvalid", {31'b0, arvalid}, 32'd0);
    chk("arst_araddr", araddr, 32'd0);
    chk("arst_rdata", data_sram_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("arst_addr_ok", {31'b0, data_sram_addr_ok}, 32'd1);
    chk("arst_arvalid_idle", {31'b0, arvalid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
